// File: rtl/icmp_pkg.sv
// Shared constants, FSM state type and helper functions for the ICMP echo responder.
package icmp_pkg;

    localparam logic [7:0]  IP_PROTO_ICMP        = 8'h01;
    localparam logic [7:0]  ICMP_TYPE_ECHO_REQ   = 8'h08;
    localparam logic [7:0]  ICMP_TYPE_ECHO_REPLY = 8'h00;
    localparam logic [7:0]  ICMP_CODE_ECHO       = 8'h00;
    localparam logic [7:0]  DEFAULT_TTL          = 8'd64;
    localparam logic [15:0] IP_ICMP_HDR_LEN      = 16'd24;

    typedef enum logic [2:0] {
        IDLE,
        RX_PAYLOAD,
        DROP,
        TX_HDR,
        TX_PAYLOAD
    } state_t;

    // Type 8 -> 0 changes the first checksum word by 0x0800; adjust incrementally.
    function automatic logic [15:0] echo_reply_csum(input logic [15:0] req_csum);
        logic [16:0] sum;
        logic [15:0] folded;
        sum    = {1'b0, ~req_csum} + 17'h0F7FF;
        folded = sum[15:0] + {15'd0, sum[16]};
        return ~folded;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/icmp_echo_buf.sv
// Simple dual-port payload store: one write port, one read port with registered output.
module icmp_echo_buf
    import icmp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_q;

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/icmp_echo_responder.sv
// Answers ICMP echo requests: buffers one request, then streams the echo reply
// with swapped addresses and an incrementally patched checksum.
module icmp_echo_responder
    import icmp_pkg::*;
#(
    parameter int BUF_DEPTH = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        s_ip_hdr_valid,
    output logic        s_ip_hdr_ready,
    input  logic [15:0] s_ip_length,
    input  logic [7:0]  s_ip_protocol,
    input  logic [31:0] s_ip_source_ip,
    input  logic [31:0] s_ip_dest_ip,
    input  logic [7:0]  s_ip_payload_axis_tdata,
    input  logic        s_ip_payload_axis_tvalid,
    output logic        s_ip_payload_axis_tready,
    input  logic        s_ip_payload_axis_tlast,
    input  logic        s_ip_payload_axis_tuser,

    output logic        m_ip_hdr_valid,
    input  logic        m_ip_hdr_ready,
    output logic [5:0]  m_ip_dscp,
    output logic [1:0]  m_ip_ecn,
    output logic [7:0]  m_ip_ttl,
    output logic [7:0]  m_ip_protocol,
    output logic [15:0] m_ip_length,
    output logic [31:0] m_ip_source_ip,
    output logic [31:0] m_ip_dest_ip,
    output logic [7:0]  m_ip_payload_axis_tdata,
    output logic        m_ip_payload_axis_tvalid,
    input  logic        m_ip_payload_axis_tready,
    output logic        m_ip_payload_axis_tlast,
    output logic        m_ip_payload_axis_tuser,

    output logic [15:0] o_reply_cnt,
    output logic [15:0] o_drop_cnt
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = AW + 2;

    state_t        state_q, state_d;
    logic [31:0]   src_ip_q, src_ip_d;
    logic [31:0]   dst_ip_q, dst_ip_d;
    logic [15:0]   csum_q, csum_d;
    logic [CW-1:0] len_q, len_d;
    logic [2:0]    hdr_idx_q, hdr_idx_d;
    logic [CW-1:0] data_cnt_q, data_cnt_d;
    logic [TW-1:0] tx_idx_q, tx_idx_d;
    logic [7:0]    tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic [15:0]   reply_cnt_q, reply_cnt_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          rx_bad;
    logic [TW-1:0] tx_total;
    logic [15:0]   reply_csum;
    logic          unused_len;

    assign unused_len = ^s_ip_length;
    assign tx_total   = TW'(len_q) + TW'(4);
    assign reply_csum = echo_reply_csum(csum_q);

    icmp_echo_buf #(
        .DEPTH (BUF_DEPTH),
        .AW    (AW)
    ) u_buf (
        .i_clk   (i_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (s_ip_payload_axis_tdata),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            src_ip_q    <= '0;
            dst_ip_q    <= '0;
            csum_q      <= '0;
            len_q       <= '0;
            hdr_idx_q   <= '0;
            data_cnt_q  <= '0;
            tx_idx_q    <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            reply_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            src_ip_q    <= src_ip_d;
            dst_ip_q    <= dst_ip_d;
            csum_q      <= csum_d;
            len_q       <= len_d;
            hdr_idx_q   <= hdr_idx_d;
            data_cnt_q  <= data_cnt_d;
            tx_idx_q    <= tx_idx_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            reply_cnt_q <= reply_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_ip_d    = src_ip_q;
        dst_ip_d    = dst_ip_q;
        csum_d      = csum_q;
        len_d       = len_q;
        hdr_idx_d   = hdr_idx_q;
        data_cnt_d  = data_cnt_q;
        tx_idx_d    = tx_idx_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        reply_cnt_d = reply_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        wr_en       = 1'b0;
        wr_addr     = data_cnt_q[AW-1:0];
        rd_en       = 1'b0;
        rd_addr     = '0;
        rx_bad      = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_ip_hdr_valid) begin
                    src_ip_d   = s_ip_source_ip;
                    dst_ip_d   = s_ip_dest_ip;
                    hdr_idx_d  = '0;
                    data_cnt_d = '0;
                    state_d    = (s_ip_protocol == IP_PROTO_ICMP) ? RX_PAYLOAD : DROP;
                end
            end

            RX_PAYLOAD: begin
                if (s_ip_payload_axis_tvalid) begin
                    case (hdr_idx_q)
                        3'd0: rx_bad = (s_ip_payload_axis_tdata != ICMP_TYPE_ECHO_REQ);
                        3'd1: rx_bad = (s_ip_payload_axis_tdata != ICMP_CODE_ECHO);
                        3'd2: csum_d[15:8] = s_ip_payload_axis_tdata;
                        3'd3: csum_d[7:0]  = s_ip_payload_axis_tdata;
                        default: begin
                            if (data_cnt_q == CW'(BUF_DEPTH)) begin
                                rx_bad = 1'b1;
                            end else begin
                                wr_en      = 1'b1;
                                data_cnt_d = data_cnt_q + CW'(1);
                            end
                        end
                    endcase
                    if (hdr_idx_q != 3'd4) begin
                        hdr_idx_d = hdr_idx_q + 3'd1;
                    end
                    if (s_ip_payload_axis_tlast) begin
                        // ICMP message must reach byte 7; data_cnt_q counts bytes from 4.
                        if (hdr_idx_q != 3'd4 || data_cnt_q < CW'(3) || s_ip_payload_axis_tuser) begin
                            rx_bad = 1'b1;
                        end
                        if (rx_bad) begin
                            drop_cnt_d = sat_inc(drop_cnt_q);
                            state_d    = IDLE;
                        end else begin
                            len_d   = data_cnt_q + CW'(1);
                            state_d = TX_HDR;
                        end
                    end else if (rx_bad) begin
                        state_d = DROP;
                    end
                end
            end

            DROP: begin
                if (s_ip_payload_axis_tvalid && s_ip_payload_axis_tlast) begin
                    drop_cnt_d = sat_inc(drop_cnt_q);
                    state_d    = IDLE;
                end
            end

            TX_HDR: begin
                // Prime the RAM output with byte 0 while the header is pending.
                rd_en    = 1'b1;
                rd_addr  = '0;
                tx_idx_d = '0;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                if (m_ip_hdr_ready) begin
                    state_d = TX_PAYLOAD;
                end
            end

            TX_PAYLOAD: begin
                if (tvalid_q && m_ip_payload_axis_tready && tlast_q) begin
                    tvalid_d    = 1'b0;
                    tlast_d     = 1'b0;
                    reply_cnt_d = sat_inc(reply_cnt_q);
                    state_d     = IDLE;
                end else if (!tvalid_q || m_ip_payload_axis_tready) begin
                    if (tx_idx_q != tx_total) begin
                        tvalid_d = 1'b1;
                        tlast_d  = (tx_idx_q == tx_total - TW'(1));
                        tx_idx_d = tx_idx_q + TW'(1);
                        if (tx_idx_q < TW'(4)) begin
                            case (tx_idx_q[1:0])
                                2'd0:    tdata_d = ICMP_TYPE_ECHO_REPLY;
                                2'd1:    tdata_d = ICMP_CODE_ECHO;
                                2'd2:    tdata_d = reply_csum[15:8];
                                default: tdata_d = reply_csum[7:0];
                            endcase
                        end else begin
                            // rd_data holds byte (idx-4); fetch (idx-3) for the next beat.
                            tdata_d = rd_data;
                            rd_en   = 1'b1;
                            rd_addr = tx_idx_q[AW-1:0] - AW'(3);
                        end
                    end else begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign s_ip_hdr_ready           = i_rst_n && (state_q == IDLE);
    assign s_ip_payload_axis_tready = i_rst_n && (state_q == RX_PAYLOAD || state_q == DROP);

    assign m_ip_hdr_valid           = (state_q == TX_HDR);
    assign m_ip_dscp                = 6'd0;
    assign m_ip_ecn                 = 2'd0;
    assign m_ip_ttl                 = DEFAULT_TTL;
    assign m_ip_protocol            = IP_PROTO_ICMP;
    assign m_ip_length              = IP_ICMP_HDR_LEN + 16'(len_q);
    assign m_ip_source_ip           = dst_ip_q;
    assign m_ip_dest_ip             = src_ip_q;
    assign m_ip_payload_axis_tdata  = tdata_q;
    assign m_ip_payload_axis_tvalid = tvalid_q;
    assign m_ip_payload_axis_tlast  = tlast_q;
    assign m_ip_payload_axis_tuser  = 1'b0;

    assign o_reply_cnt = reply_cnt_q;
    assign o_drop_cnt  = drop_cnt_q;

endmodule
